// File: rtl/ga_chrom_queue_pkg.sv
// ga_chrom_queue_pkg: shared sizing constants for the chromosome queue
package ga_chrom_queue_pkg;
  localparam int CHROM_MAX_W = 64;
  localparam int QUEUE_DEPTH = 8;
  localparam int QUEUE_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int QUEUE_CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int SIM_DLY     = 1;
endpackage

// File: rtl/ga_chrom_queue_mem.sv
// ga_chrom_queue_mem: unreset storage array, one write port and one asynchronous read port
module ga_chrom_queue_mem #(
  parameter int W  = 64,
  parameter int D  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  // write the slot addressed by the write pointer
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ga_chrom_queue.sv
// ga_chrom_queue: chromosome FIFO between the mutation/crossover stage and the fitness FSM
module ga_chrom_queue
  import ga_chrom_queue_pkg::*;
#(
  parameter int CHROM_MAX_W = ga_chrom_queue_pkg::CHROM_MAX_W,
  parameter int QUEUE_DEPTH = ga_chrom_queue_pkg::QUEUE_DEPTH,
  parameter int QUEUE_PTR_W = $clog2(QUEUE_DEPTH),
  parameter int QUEUE_CNT_W = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst,
  input  logic                   push_valid,
  input  logic [CHROM_MAX_W-1:0] push_chrom,
  output logic                   push_ready,
  input  logic                   queue_pop,
  output logic                   queue_not_empty,
  output logic [CHROM_MAX_W-1:0] o_pop_chrom,
  output logic                   o_pop_vld_pls,
  output logic [QUEUE_CNT_W-1:0] o_queue_cnt,
  output logic                   o_ovf_err,
  output logic                   o_udf_err
);
  localparam logic [QUEUE_PTR_W:0]   DEPTH_P = QUEUE_DEPTH[QUEUE_PTR_W:0];
  localparam logic [QUEUE_CNT_W-1:0] DEPTH_C = QUEUE_DEPTH[QUEUE_CNT_W-1:0];
  logic [QUEUE_PTR_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [QUEUE_PTR_W:0]   wr_inc, rd_inc;
  logic [CHROM_MAX_W-1:0] rdata;
  logic                   push_acc, pop_acc;
  assign push_ready      = o_queue_cnt != DEPTH_C;
  assign queue_not_empty = o_queue_cnt != '0;
  assign push_acc        = push_valid & push_ready;
  assign pop_acc         = queue_pop & queue_not_empty;
  // pointer increments widened by one bit so the wrap compare works for any depth
  always_comb begin
    wr_inc = {1'b0, wr_ptr} + (QUEUE_PTR_W+1)'(1);
    rd_inc = {1'b0, rd_ptr} + (QUEUE_PTR_W+1)'(1);
    wr_nxt = (wr_inc == DEPTH_P) ? '0 : wr_inc[QUEUE_PTR_W-1:0];
    rd_nxt = (rd_inc == DEPTH_P) ? '0 : rd_inc[QUEUE_PTR_W-1:0];
  end
  ga_chrom_queue_mem #(.W(CHROM_MAX_W), .D(QUEUE_DEPTH), .AW(QUEUE_PTR_W)) u_mem (
    .clk   (clk),
    .we    (push_acc & ~sw_rst),
    .waddr (wr_ptr),
    .wdata (push_chrom),
    .raddr (rd_ptr),
    .rdata (rdata)
  );
  // pointers, occupancy, sticky errors and the registered pop output
  always_ff @(posedge clk or posedge rst)
    if (rst || sw_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_queue_cnt   <= '0;
      o_pop_chrom   <= '0;
      o_pop_vld_pls <= 1'b0;
      o_ovf_err     <= 1'b0;
      o_udf_err     <= 1'b0;
    end else begin
      wr_ptr        <= push_acc ? wr_nxt : wr_ptr;
      rd_ptr        <= pop_acc ? rd_nxt : rd_ptr;
      o_queue_cnt   <= (push_acc & ~pop_acc) ? o_queue_cnt + QUEUE_CNT_W'(1) :
                       (pop_acc & ~push_acc) ? o_queue_cnt - QUEUE_CNT_W'(1) : o_queue_cnt;
      o_pop_chrom   <= pop_acc ? rdata : o_pop_chrom;
      o_pop_vld_pls <= pop_acc;
      o_ovf_err     <= o_ovf_err | (push_valid & ~push_ready);
      o_udf_err     <= o_udf_err | (queue_pop & ~queue_not_empty);
    end
endmodule

// File: tb/tb_ga_chrom_queue.sv
// tb_ga_chrom_queue: directed and random checks of ga_chrom_queue against a queue-based model
module tb_ga_chrom_queue;
  localparam int W  = 64;
  localparam int D  = 8;
  localparam int CW = 4;
  logic         clk = 0, rst = 1, sw_rst = 0, push_valid = 0, queue_pop = 0;
  logic [W-1:0] push_chrom = '0;
  logic         push_ready, queue_not_empty, o_pop_vld_pls, o_ovf_err, o_udf_err;
  logic [W-1:0] o_pop_chrom;
  logic [CW-1:0] o_queue_cnt;
  int checks = 0, failures = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_chrom;
  logic         m_vld, m_ovf, m_udf;

  ga_chrom_queue dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst),
    .push_valid(push_valid), .push_chrom(push_chrom), .push_ready(push_ready),
    .queue_pop(queue_pop), .queue_not_empty(queue_not_empty),
    .o_pop_chrom(o_pop_chrom), .o_pop_vld_pls(o_pop_vld_pls), .o_queue_cnt(o_queue_cnt),
    .o_ovf_err(o_ovf_err), .o_udf_err(o_udf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_chrom = '0;
    m_vld = 0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ":cnt"}, W'(o_queue_cnt), W'(q.size()));
    chk({tag, ":ready"}, W'(push_ready), W'(q.size() != D));
    chk({tag, ":not_empty"}, W'(queue_not_empty), W'(q.size() != 0));
    chk({tag, ":chrom"}, o_pop_chrom, m_chrom);
    chk({tag, ":vld"}, W'(o_pop_vld_pls), W'(m_vld));
    chk({tag, ":ovf"}, W'(o_ovf_err), W'(m_ovf));
    chk({tag, ":udf"}, W'(o_udf_err), W'(m_udf));
  endtask

  // one clock: drive inputs, let the model consume the same edge, compare #1 later
  task automatic step(input logic pv, input logic [W-1:0] pc, input logic pp, input logic sr, input string tag);
    bit full, empty;
    push_valid = pv;
    push_chrom = pc;
    queue_pop  = pp;
    sw_rst     = sr;
    full  = q.size() == D;
    empty = q.size() == 0;
    @(posedge clk);
    if (sr) model_reset();
    else begin
      m_vld = pp && !empty;
      if (m_vld) m_chrom = q.pop_front();
      if (pv && !full) q.push_back(pc);
      m_ovf = m_ovf | (pv && full);
      m_udf = m_udf | (pp && empty);
    end
    #1;
    chk_all(tag);
    push_valid = 0;
    queue_pop  = 0;
    sw_rst     = 0;
  endtask

  initial begin
    int pulses;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_all("reset");
    for (int i = 1; i <= 3; i++) step(1, W'(i), 0, 0, "pre_rst");
    #2 rst = 1;
    #1 model_reset();
    chk_all("async_rst");
    @(posedge clk);
    #1 rst = 0;
    for (int i = 1; i <= D; i++) step(1, W'(i * 'h11), 0, 0, "fill");
    chk("full_ready", W'(push_ready), '0);
    chk("full_cnt", W'(o_queue_cnt), W'(8));
    step(1, W'('h99), 0, 0, "ovf");
    chk("ovf_flag", W'(o_ovf_err), W'(1));
    for (int i = 1; i <= D; i++) begin
      step(0, '0, 1, 0, "drain");
      chk("drain_val", o_pop_chrom, W'(i * 'h11));
      chk("drain_pls", W'(o_pop_vld_pls), W'(1));
    end
    chk("drained_ne", W'(queue_not_empty), '0);
    for (int i = 1; i <= D; i++) step(1, W'('h100 + i), 0, 0, "refill");
    step(1, W'('hEE), 1, 0, "full_both");
    chk("full_both_val", o_pop_chrom, W'('h101));
    chk("full_both_cnt", W'(o_queue_cnt), W'(7));
    step(1, W'('hFF), 0, 0, "wrap_push");
    chk("wrap_cnt", W'(o_queue_cnt), W'(8));
    for (int i = 2; i <= D + 1; i++) begin
      step(0, '0, 1, 0, "wrap_drain");
      chk("wrap_val", o_pop_chrom, (i <= D) ? W'('h100 + i) : W'('hFF));
    end
    step(1, W'('hAB), 1, 0, "empty_both");
    chk("empty_both_cnt", W'(o_queue_cnt), W'(1));
    chk("empty_both_udf", W'(o_udf_err), W'(1));
    chk("empty_both_chrom", o_pop_chrom, W'('hFF));
    chk("empty_both_pls", W'(o_pop_vld_pls), '0);
    step(0, '0, 1, 0, "pop_ab");
    chk("pop_ab_val", o_pop_chrom, W'('hAB));
    for (int i = 0; i < 5; i++) step(1, W'('h200 + i), 0, 0, "pre_sw");
    step(1, W'('hCC), 0, 1, "sw_rst");
    chk("sw_cnt", W'(o_queue_cnt), '0);
    chk("sw_udf", W'(o_udf_err), '0);
    chk("sw_ovf", W'(o_ovf_err), '0);
    step(0, '0, 1, 0, "sw_discard");
    chk("sw_discard_pls", W'(o_pop_vld_pls), '0);
    step(1, W'('h5A), 0, 0, "hold_push");
    step(0, '0, 1, 0, "hold_pop");
    pulses = int'(o_pop_vld_pls);
    for (int i = 0; i < 50; i++) begin
      step(0, '0, 0, 0, "hold_idle");
      chk("hold_val", o_pop_chrom, W'('h5A));
      pulses += int'(o_pop_vld_pls);
    end
    chk("hold_pulses", W'(pulses), W'(1));
    for (int i = 0; i < 3000; i++)
      step($urandom_range(9, 0) < 6, {$urandom, $urandom}, $urandom_range(1, 0) == 1,
           $urandom_range(63, 0) == 0, "random");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
